prefix_subtractor_pipe: RTL and testbench
=========================================

# prefix_subtractor_pipe

Pipelined WIDTH-bit unsigned/two's-complement subtractor that computes `diff = a - b` as `a + ~b + 1`. It uses the same Sklansky-style parallel-prefix propagate/generate carry network as the team's combinational prefix adders, with carry-in forced to 1. It sits between an operand producer and a result consumer, and both sides use valid/ready handshakes. It is the inverse-direction companion to the 8-bit prefix adder and is used wherever operand differences, borrows and equality are needed at register boundaries.

## Interface
Parameters:
- WIDTH, 8, operand width; must be a power of two, 4..32.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts result this cycle.
- diff  output  WIDTH  `a - b` modulo 2^WIDTH.
- borrow  output  1  1 when `a < b` unsigned (inverse of final carry-out).
- zero  output  1  1 when `diff == 0`.
- ovf  output  1  signed overflow: `a[W-1] != b[W-1]` and `diff[W-1] != a[W-1]`.

## Operation
- Stage 1 (S1): on accept, registers `p_i = a_i ^ ~b_i` and `g_i = a_i & ~b_i` for all bits, plus `a[W-1]` and `b[W-1]`. Sets `s1_valid`.
- Stage 2 (S2): on advance from S1, evaluates the log2(WIDTH)-level prefix tree. The carry-in of 1 is folded in as `g_-1 = 1` at bit 0, so `c_i = G[i:0] | P[i:0]`. It registers `diff_i = p_i ^ c_{i-1}`, `borrow = ~c_{W-1}`, `zero`, and `ovf`. Sets `s2_valid`.
- The prefix network uses only BLACK (g,p pair) and GREY (g only) cells. Fan-out follows the Sklansky pattern: level k combines bit i with bit `(i | (2^k-1)) - 2^k`-block head.
- Handshake and flow control:
  - `out_valid = s2_valid`.
  - S2 loads when `!s2_valid || out_ready`.
  - S1 advances into S2 under the same condition.
  - `in_ready = !s1_valid || (!s2_valid || out_ready)`. This is combinational from `out_ready`; no skid buffer.
  - A transfer happens only when valid and ready are both high in the same cycle.
  - Outputs hold stable while `out_valid && !out_ready`.
- Simultaneous accept and advance in one cycle is legal. S1 is overwritten with new operands while its old contents move to S2.
- Full pipeline (both stages valid) with `out_ready = 0`: `in_ready = 0` and no state changes.
- Reset, including mid-operation: `s1_valid = s2_valid = 0` immediately. Datapath registers and `diff`, `borrow`, `zero`, `ovf` clear to 0. `in_ready` reads 1 once `rst_n` is high.

## Timing
- Latency is 2 cycles from an accepted input to `out_valid`, with no backpressure.
- Throughput is one result per cycle when `out_ready` is held high.
- Output reset values: `out_valid=0`, `diff=0`, `borrow=0`, `zero=0`, `ovf=0`. `in_ready=1` (combinational from cleared valids).
- All outputs except `in_ready` are driven directly from flops.

## Configuration
- `SUB_SATURATE_EN`:
  - When defined: when `borrow` would be 1, S2 registers `diff = 0` and `zero = 1`. `borrow` still reports 1, giving unsigned saturating subtraction.
  - When undefined: `diff` wraps modulo 2^WIDTH and `zero` reflects the wrapped value.
  - Handshake and latency are identical in both builds.

## Test plan
- Basic subtraction (WIDTH=8, `out_ready=1`), accept `a=0x5A`, `b=0x21` -> two cycles later `diff=0x39`, `borrow=0`, `zero=0`, `ovf=0`.
- Borrow and saturation:
  - Non-saturating build, `a=0x03`, `b=0x05` -> `diff=0xFE`, `borrow=1`, `zero=0`.
  - `SUB_SATURATE_EN` build, same operands -> `diff=0x00`, `borrow=1`, `zero=1`.
- Equality and signed overflow:
  - `a=0x7F`, `b=0x7F` -> `diff=0x00`, `zero=1`, `borrow=0`.
  - `a=0x80`, `b=0x01` -> `diff=0x7F`, `ovf=1`, `borrow=0`.
- Backpressure: stream 4 operand pairs back-to-back while `out_ready=0` -> `in_ready` falls after 2 accepts. Release `out_ready` -> 4 results in order, none lost or duplicated, and outputs held stable during the stall.
- Reset mid-stream: assert `rst_n=0` with both stages valid -> `out_valid` drops asynchronously and all outputs read 0. After release, the first new pair's result appears exactly 2 cycles after acceptance.
- Exhaustive check at WIDTH=8: all 65536 pairs at full throughput, compared against a reference model for `diff`, `borrow`, `zero` and `ovf`.

Source files
------------

// File: rtl/prefix_subtractor_pipe_if.sv
// Operand/result handshake bundle for prefix_subtractor_pipe.
// The master side is the operand producer and result consumer; the slave side is the subtractor.
interface prefix_subtractor_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, zero, ovf
  );
endinterface

// File: rtl/prefix_subtractor_pipe.sv
// Two-stage valid/ready subtractor, diff = a + ~b + 1, using a Sklansky prefix carry tree.
// Optional macro SUB_SATURATE_EN clamps diff to 0 on borrow (unsigned saturating subtract).

module psp_black_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);
  assign g = gh | (ph & gl);
  assign p = ph & pl;
endmodule

module prefix_subtractor_pipe #(
  parameter int WIDTH = 8   // power of two, 4..32
) (
  input  logic clk,
  input  logic rst_n,
  prefix_subtractor_pipe_if.slave bus
);
  localparam int LV = $clog2(WIDTH);

  logic [2:1]       vld_pipe;
  logic             advance;
  logic             accept;

  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic             s1_a_msb;
  logic             s1_b_msb;

  logic [LV:0][WIDTH-1:0] gt;
  logic [LV:0][WIDTH-1:0] pt;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] diff_raw;
  logic [WIDTH-1:0] diff_nxt;
  logic             borrow_nxt;
  logic             zero_nxt;
  logic             ovf_nxt;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             zero_q;
  logic             ovf_q;

  assign advance      = !vld_pipe[2] || bus.out_ready;
  assign bus.in_ready = !vld_pipe[1] || advance;
  assign accept       = bus.in_valid && bus.in_ready;

  // Sklansky tree: at level k, bit i (bit k of i set) takes the head of the block below it.
  assign gt[0] = s1_g;
  assign pt[0] = s1_p;

  for (genvar k = 0; k < LV; k++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i >> k) & 1) == 1) begin : g_cell
        localparam int J = ((i >> k) << k) - 1;
        psp_black_cell u_cell (
          .gh(gt[k][i]), .ph(pt[k][i]),
          .gl(gt[k][J]), .pl(pt[k][J]),
          .g (gt[k+1][i]), .p(pt[k+1][i])
        );
      end else begin : g_pass
        assign gt[k+1][i] = gt[k][i];
        assign pt[k+1][i] = pt[k][i];
      end
    end
  end

  // Carry-in of 1 enters as g_-1 = 1, so every prefix that fully propagates also carries.
  assign c          = gt[LV] | pt[LV];
  assign diff_raw   = s1_p ^ {c[WIDTH-2:0], 1'b1};
  assign borrow_nxt = ~c[WIDTH-1];
  // Overflow describes the arithmetic itself, so it is taken from the wrapped difference.
  assign ovf_nxt    = (s1_a_msb != s1_b_msb) && (diff_raw[WIDTH-1] != s1_a_msb);
`ifdef SUB_SATURATE_EN
  assign diff_nxt   = borrow_nxt ? '0 : diff_raw;
`else
  assign diff_nxt   = diff_raw;
`endif
  assign zero_nxt   = (diff_nxt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      vld_pipe[1] <= accept || (vld_pipe[1] && !advance);
      if (accept) begin
        s1_p     <= bus.a ^ ~bus.b;
        s1_g     <= bus.a & ~bus.b;
        s1_a_msb <= bus.a[WIDTH-1];
        s1_b_msb <= bus.b[WIDTH-1];
      end
      if (advance) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          diff_q   <= diff_nxt;
          borrow_q <= borrow_nxt;
          zero_q   <= zero_nxt;
          ovf_q    <= ovf_nxt;
        end
      end
    end
  end

  assign bus.out_valid = vld_pipe[2];
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Bench for prefix_subtractor_pipe (WIDTH=8): directed table, handshake corner cases,
// exhaustive full-throughput sweep and random backpressure against an arithmetic model.
module tb_prefix_subtractor_pipe;
  typedef struct packed {
    logic [7:0] d;
    logic       br;
    logic       z;
    logic       ov;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    res_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  res_t exp_q[$];
  res_t held;
  logic held_valid = 1'b0;

  prefix_subtractor_pipe_if #(.WIDTH(8)) bus ();
  prefix_subtractor_pipe #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic res_t model(input logic [7:0] x, input logic [7:0] y);
    res_t r;
    int   sd;
    r.br = (x < y);
    r.d  = x - y;
    sd   = int'($signed(x)) - int'($signed(y));
    r.ov = (sd > 127) || (sd < -128);
`ifdef SUB_SATURATE_EN
    if (r.br) r.d = 8'h00;
`endif
    r.z  = (r.d == 8'h00);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic res_t outs();
    res_t r;
    r.d = bus.diff; r.br = bus.borrow; r.z = bus.zero; r.ov = bus.ovf;
    return r;
  endfunction

  // One cycle: drive at negedge, observe handshakes 1ns later, return at the next negedge.
  task automatic do_cycle(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ordy, output logic acc);
    res_t e;
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.out_ready = ordy;
    #1;
    acc = iv && bus.in_ready;
    if (acc) exp_q.push_back(model(ia, ib));
    if (held_valid) begin
      chk("stall_valid_held", 32'(bus.out_valid), 32'd1);
      chk("stall_outputs_held", 32'(outs()), 32'(held));
    end
    held_valid = 1'b0;
    if (bus.out_valid) begin
      if (ordy) begin
        n_out++;
        if (exp_q.size() == 0) chk("unexpected_result", 32'(outs()), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("result", 32'(outs()), 32'(e));
        end
      end else begin
        held       = outs();
        held_valid = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      do_cycle(1'b0, 8'h00, 8'h00, 1'b1, acc);
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t vecs[8];
    logic acc;
    int   n0, k, accs, idx, budget;
    logic [7:0] pa[4], pb[4];

    vecs[0] = '{8'h5A, 8'h21, '{8'h39, 1'b0, 1'b0, 1'b0}};
`ifdef SUB_SATURATE_EN
    vecs[1] = '{8'h03, 8'h05, '{8'h00, 1'b1, 1'b1, 1'b0}};
    vecs[6] = '{8'h00, 8'hFF, '{8'h00, 1'b1, 1'b1, 1'b0}};
    vecs[7] = '{8'h7F, 8'hFF, '{8'h00, 1'b1, 1'b1, 1'b1}};
`else
    vecs[1] = '{8'h03, 8'h05, '{8'hFE, 1'b1, 1'b0, 1'b0}};
    vecs[6] = '{8'h00, 8'hFF, '{8'h01, 1'b1, 1'b0, 1'b0}};
    vecs[7] = '{8'h7F, 8'hFF, '{8'h80, 1'b1, 1'b0, 1'b1}};
`endif
    vecs[2] = '{8'h7F, 8'h7F, '{8'h00, 1'b0, 1'b1, 1'b0}};
    vecs[3] = '{8'h80, 8'h01, '{8'h7F, 1'b0, 1'b0, 1'b1}};
    vecs[4] = '{8'h00, 8'h00, '{8'h00, 1'b0, 1'b1, 1'b0}};
    vecs[5] = '{8'hFF, 8'h00, '{8'hFF, 1'b0, 1'b0, 1'b0}};

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_outputs", 32'(outs()), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Directed table: one pair at a time, result expected on the second cycle.
    for (int v = 0; v < 8; v++) begin
      bus.in_valid = 1'b1; bus.a = vecs[v].a; bus.b = vecs[v].b; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 chk("table_latency_early", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("table_valid", 32'(bus.out_valid), 32'd1);
      chk($sformatf("table_vec%0d", v), 32'(outs()), 32'(vecs[v].exp));
      @(negedge clk);
    end

    // Backpressure: four pairs offered with out_ready low, two fit.
    for (int i = 0; i < 4; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
    accs = 0;
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, pa[accs], pb[accs], 1'b0, acc);
      if (acc) accs++;
    end
    chk("stall_accepts", 32'(accs), 32'd2);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    #1 chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    n0 = n_out;
    budget = 0;
    while (accs < 4 && budget < 20) begin
      do_cycle(1'b1, pa[accs], pb[accs], 1'b1, acc);
      if (acc) accs++;
      budget++;
    end
    drain();
    chk("stall_result_count", 32'(n_out - n0), 32'd4);

    // Reset with both stages full.
    do_cycle(1'b1, 8'h12, 8'h34, 1'b0, acc);
    do_cycle(1'b1, 8'h56, 8'h78, 1'b0, acc);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_outputs", 32'(outs()), 32'd0);
    exp_q.delete();
    held_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    do_cycle(1'b1, 8'h5A, 8'h21, 1'b1, acc);
    chk("midrst_accept", 32'(acc), 32'd1);
    n0 = n_out;
    k = 0;
    for (int i = 1; i <= 5; i++) begin
      do_cycle(1'b0, 8'h00, 8'h00, 1'b1, acc);
      if (n_out != n0) begin k = i; break; end
    end
    chk("midrst_latency", 32'(k), 32'd2);

    // Exhaustive sweep at full throughput.
    idx = 0;
    budget = 0;
    while (idx < 65536 && budget < 70000) begin
      do_cycle(1'b1, 8'(idx >> 8), 8'(idx), 1'b1, acc);
      if (acc) idx++;
      budget++;
    end
    chk("exhaustive_all_accepted", 32'(idx), 32'd65536);
    chk("exhaustive_throughput", 32'(budget), 32'd65536);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 2000; i++)
      do_cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 9) < 6), acc);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
